// File: rtl/reg_wb_arbiter.sv
// -----------------------------------------------------------------------------
// reg_wb_arbiter
//
// Writeback stage for the register file write port (we3/a3/wd3).
// Single-cycle ALU results always take the port. Long-latency (LL) results are
// queued in a small FIFO and written whenever the ALU leaves the port idle.
// A busy-bit scoreboard tracks registers with an outstanding LL write and
// stalls decode on any operand or destination hazard against them.
//
// Optional feature: define WB_STARVE_GUARD_EN to enable the starvation guard.
// It counts cycles where a queued LL result loses the port to the ALU and
// raises alu_hold once STARVE_LIMIT is reached, until the FIFO dequeues.
// Without the macro alu_hold is tied low and ALU priority is strict.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   alu_we/alu_rd/alu_wd     ALU result (no backpressure)
//   ll_valid/ll_ready        LL result handshake
//   ll_rd/ll_wd              LL result destination and data
//   dec_valid/dec_ll         decode holds an instruction / it is long-latency
//   dec_rs1/dec_rs2/dec_rd   decoded operand and destination registers
//   stall                    decode must hold this cycle
//   alu_hold                 upstream must not present alu_we next cycle
//   we3/a3/wd3               register file write port
// -----------------------------------------------------------------------------
module reg_wb_arbiter #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int FIFO_DEPTH    = 2,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_we,
   input  logic [ADDRESS_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0]    alu_wd,
   input  logic                     ll_valid,
   output logic                     ll_ready,
   input  logic [ADDRESS_WIDTH-1:0] ll_rd,
   input  logic [DATA_WIDTH-1:0]    ll_wd,
   input  logic                     dec_valid,
   input  logic                     dec_ll,
   input  logic [ADDRESS_WIDTH-1:0] dec_rs1,
   input  logic [ADDRESS_WIDTH-1:0] dec_rs2,
   input  logic [ADDRESS_WIDTH-1:0] dec_rd,
   output logic                     stall,
   output logic                     alu_hold,
   output logic                     we3,
   output logic [ADDRESS_WIDTH-1:0] a3,
   output logic [DATA_WIDTH-1:0]    wd3
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int NREG  = 1 << ADDRESS_WIDTH;

   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0]    wd;
   } entry_t;

   entry_t             mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [CNT_W-1:0]   count;
   logic [NREG-1:0]    busy;

   logic alu_win;
   logic fifo_empty;
   logic fifo_full;
   logic enq;
   logic deq;
   logic issue;

   // NOTE: every signal driven here gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      alu_win    = alu_we && (alu_rd != '0);
      fifo_empty = (count == '0);
      fifo_full  = (count == CNT_W'(FIFO_DEPTH));
      // Full blocks acceptance even when a dequeue happens this cycle.
      ll_ready   = !rst && !fifo_full;
      // Results aimed at x0 are accepted but never stored.
      enq        = ll_valid && ll_ready && (ll_rd != '0);
      deq        = !rst && !alu_win && !fifo_empty;

      we3 = 1'b0;
      a3  = '0;
      wd3 = '0;
      if (!rst) begin
         if (alu_win) begin
            we3 = 1'b1;
            a3  = alu_rd;
            wd3 = alu_wd;
         end else if (!fifo_empty) begin
            we3 = 1'b1;
            a3  = mem[head].rd;
            wd3 = mem[head].wd;
         end
      end

      stall = !rst && dec_valid && (busy[dec_rs1] || busy[dec_rs2] || busy[dec_rd]);
      issue = dec_valid && dec_ll && !stall && (dec_rd != '0);
   end

   // NOTE: the storage array carries no reset; the count and pointers decide
   // which entries are live, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (enq) mem[tail] <= '{rd: ll_rd, wd: ll_wd};
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         busy  <= '0;
      end else begin
         if (enq) tail <= tail + 1'b1;
         if (deq) head <= head + 1'b1;
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // Clear before set: the later assignment wins on a shared index.
         if (deq)   busy[mem[head].rd] <= 1'b0;
         if (issue) busy[dec_rd]       <= 1'b1;
      end
   end

`ifdef WB_STARVE_GUARD_EN
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);

   logic [SC_W-1:0] starve_cnt;
   logic [SC_W-1:0] starve_next;
   logic            hold_q;

   always_comb begin
      starve_next = starve_cnt;
      if (fifo_empty || deq)
         starve_next = '0;
      else if (alu_win && (starve_cnt != SC_W'(STARVE_LIMIT)))
         starve_next = starve_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
         hold_q     <= 1'b0;
      end else begin
         starve_cnt <= starve_next;
         if (deq)
            hold_q <= 1'b0;
         else if (starve_next == SC_W'(STARVE_LIMIT))
            hold_q <= 1'b1;
      end
   end

   assign alu_hold = hold_q && !rst;
`else
   assign alu_hold = 1'b0;
`endif

endmodule
